// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared HD44780 command bytes, controller state encoding and strobe decode
//   No ports. Imported by lcd_display_controller and lcd_cursor_counter.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET_2L = 8'h38;  // 8-bit bus, 2 display lines, 5x8 font
  localparam logic [7:0] FUNC_SET_1L = 8'h30;  // 8-bit bus, 1 display line, 5x8 font
  localparam logic [7:0] CLEAR       = 8'h01;
  localparam logic [7:0] DISP_ON     = 8'h0C;  // display on, cursor off, blink off
  localparam logic [7:0] ENTRY_INC   = 8'h06;  // increment address, no shift
  localparam logic [7:0] SET_DDRAM   = 8'h80;
  localparam logic [7:0] ROW1_BASE   = 8'h40;

  typedef enum logic [3:0] {
    S_POWER_WAIT = 4'd0,
    S_FS1        = 4'd1,
    S_FS2        = 4'd2,
    S_FS3        = 4'd3,
    S_FS4        = 4'd4,
    S_CLEAR      = 4'd5,
    S_CLEAR_WAIT = 4'd6,
    S_DISP_CTRL  = 4'd7,
    S_ENTRY      = 4'd8,
    S_IDLE       = 4'd9,
    S_SET_ADDR   = 4'd10,
    S_WRITE_CHAR = 4'd11
  } lcd_state_t;

  // States that put a byte on DB and therefore need an E pulse.
  function automatic logic state_strobes(lcd_state_t s);
    case (s)
      S_FS1, S_FS2, S_FS3, S_FS4, S_CLEAR, S_DISP_CTRL,
      S_ENTRY, S_SET_ADDR, S_WRITE_CHAR: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lcd_display_controller_if.sv
// rtl/lcd_display_controller_if.sv - character source and LCD pin bundle of the LCD controller
//   Parameter IW : width of char_index
//   master : character source / system side (drives start, char_data)
//   slave  : controller side (drives char_index, busy, frame_done, RS, RW, E, DB)
interface lcd_display_controller_if #(
  parameter int IW = 5
);
  logic          start;
  logic [7:0]    char_data;
  logic [IW-1:0] char_index;
  logic          busy;
  logic          frame_done;
  logic          RS;
  logic          RW;
  logic          E;
  logic [7:0]    DB;

  modport master (
    output start, char_data,
    input  char_index, busy, frame_done, RS, RW, E, DB
  );

  modport slave (
    input  start, char_data,
    output char_index, busy, frame_done, RS, RW, E, DB
  );
endinterface

// File: rtl/lcd_cursor_counter.sv
// rtl/lcd_cursor_counter.sv - row/column/linear-index cursor for frame streaming
//   i_clk, i_reset  : clock, asynchronous active-high reset
//   i_advance       : step the cursor by one character
//   i_clear         : return cursor to row 0, column 0 (wins over i_advance)
//   o_char_index    : linear index row*COLS+col
//   o_last_col      : cursor is in the last column of a row
//   o_last_char     : cursor is on the last character of the frame
//   o_row_base      : DDRAM base address of the current row
module lcd_cursor_counter
  import lcd_pkg::*;
#(
  parameter int COLS = 16,
  parameter int ROWS = 2,
  parameter int IW   = 5
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_advance,
  input  logic          i_clear,
  output logic [IW-1:0] o_char_index,
  output logic          o_last_col,
  output logic          o_last_char,
  output logic [7:0]    o_row_base
);

  localparam int CW  = $clog2(COLS);
  localparam int RWD = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [CW-1:0]  r_col;
  logic [RWD-1:0] r_row;
  logic [IW-1:0]  r_index;
  logic           w_last_row;

  assign o_last_col   = (r_col == CW'(COLS - 1));
  assign w_last_row   = (r_row == RWD'(ROWS - 1));
  assign o_last_char  = o_last_col && w_last_row;
  assign o_char_index = r_index;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_col   <= '0;
      r_row   <= '0;
      r_index <= '0;
    end else if (i_clear || (i_advance && o_last_char)) begin
      r_col   <= '0;
      r_row   <= '0;
      r_index <= '0;
    end else if (i_advance) begin
      r_index <= r_index + IW'(1);
      if (o_last_col) begin
        r_col <= '0;
        r_row <= r_row + RWD'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Rows 2 and 3 of a 4-line module continue rows 0 and 1 in DDRAM.
  always_comb begin
    o_row_base = 8'h00;
    case (int'(r_row))
      1:       o_row_base = ROW1_BASE;
      2:       o_row_base = 8'(COLS);
      3:       o_row_base = ROW1_BASE + 8'(COLS);
      default: o_row_base = 8'h00;
    endcase
  end

endmodule

// File: rtl/lcd_display_controller.sv
// rtl/lcd_display_controller.sv - HD44780 8-bit write-only init and frame streaming controller
//   clock500Hz : 2 ms system/LCD clock
//   reset      : asynchronous, active-high
//   bus        : slave modport; start/char_data in, char_index/busy/frame_done/RS/RW/E/DB out
module lcd_display_controller #(
  parameter int COLS           = 16,
  parameter int ROWS           = 2,
  parameter int POWERUP_CYCLES = 20,
  parameter int CLEAR_WAIT     = 1,
  parameter int CONTINUOUS     = 1
) (
  input logic                      clock500Hz,
  input logic                      reset,
  lcd_display_controller_if.slave  bus
);
  import lcd_pkg::*;

  localparam int IW   = $clog2(ROWS * COLS);
  localparam int WMAX = (POWERUP_CYCLES > CLEAR_WAIT) ? POWERUP_CYCLES : CLEAR_WAIT;
  localparam int WW   = $clog2(WMAX + 1);
  localparam logic [7:0] FS_CMD = (ROWS >= 2) ? FUNC_SET_2L : FUNC_SET_1L;

  lcd_state_t    r_state, w_state_next;
  logic [WW-1:0] r_wait;
  logic          r_e_en;
  logic          r_frame_done;
  logic          w_wait_done;
  logic          w_advance;
  logic          w_clear;
  logic          w_last_col;
  logic          w_last_char;
  logic [IW-1:0] w_char_index;
  logic [7:0]    w_row_base;
  logic          w_rs;
  logic [7:0]    w_db;

  lcd_cursor_counter #(
    .COLS (COLS),
    .ROWS (ROWS),
    .IW   (IW)
  ) u_cursor (
    .i_clk        (clock500Hz),
    .i_reset      (reset),
    .i_advance    (w_advance),
    .i_clear      (w_clear),
    .o_char_index (w_char_index),
    .o_last_col   (w_last_col),
    .o_last_char  (w_last_char),
    .o_row_base   (w_row_base)
  );

  assign w_wait_done = ((r_state == S_POWER_WAIT) && (r_wait == WW'(POWERUP_CYCLES - 1))) ||
                       ((r_state == S_CLEAR_WAIT) && (r_wait == WW'(CLEAR_WAIT - 1)));

  always_ff @(posedge clock500Hz or posedge reset) begin
    if (reset) begin
      r_state      <= S_POWER_WAIT;
      r_wait       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      if (((r_state == S_POWER_WAIT) || (r_state == S_CLEAR_WAIT)) && !w_wait_done)
        r_wait <= r_wait + WW'(1);
      else
        r_wait <= '0;
      r_frame_done <= (r_state == S_WRITE_CHAR) && w_last_char;
    end
  end

  // e_en looks ahead at the state about to be entered, so E rises at the
  // start of a strobing state and falls mid-cycle while DB is still stable.
  always_ff @(negedge clock500Hz or posedge reset) begin
    if (reset) r_e_en <= 1'b0;
    else       r_e_en <= state_strobes(w_state_next);
  end

  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    w_clear      = 1'b0;
    w_rs         = 1'b0;
    w_db         = 8'h00;
    case (r_state)
      S_POWER_WAIT: begin
        w_clear = 1'b1;
        if (w_wait_done) w_state_next = S_FS1;
      end
      S_FS1:        begin w_db = FS_CMD;    w_state_next = S_FS2;        end
      S_FS2:        begin w_db = FS_CMD;    w_state_next = S_FS3;        end
      S_FS3:        begin w_db = FS_CMD;    w_state_next = S_FS4;        end
      S_FS4:        begin w_db = FS_CMD;    w_state_next = S_CLEAR;      end
      S_CLEAR:      begin w_db = CLEAR;     w_state_next = S_CLEAR_WAIT; end
      S_CLEAR_WAIT: if (w_wait_done) w_state_next = S_DISP_CTRL;
      S_DISP_CTRL:  begin w_db = DISP_ON;   w_state_next = S_ENTRY;      end
      S_ENTRY: begin
        w_db         = ENTRY_INC;
        w_state_next = (CONTINUOUS != 0) ? S_SET_ADDR : S_IDLE;
      end
      S_IDLE: if ((CONTINUOUS == 0) && bus.start) w_state_next = S_SET_ADDR;
      S_SET_ADDR: begin
        w_db         = SET_DDRAM | w_row_base;
        w_state_next = S_WRITE_CHAR;
      end
      S_WRITE_CHAR: begin
        w_rs      = 1'b1;
        w_db      = bus.char_data;
        w_advance = 1'b1;
        if (w_last_char)     w_state_next = (CONTINUOUS != 0) ? S_SET_ADDR : S_IDLE;
        else if (w_last_col) w_state_next = S_SET_ADDR;
      end
      default: w_state_next = S_POWER_WAIT;
    endcase
  end

  assign bus.char_index = w_char_index;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.frame_done = r_frame_done;
  assign bus.RS         = w_rs;
  assign bus.RW         = 1'b0;
  assign bus.DB         = w_db;
  assign bus.E          = clock500Hz & r_e_en;

endmodule

// File: doc/lcd_display_controller.md
Name: lcd_display_controller

Overview:
- Parametrised HD44780-class character LCD controller, 8-bit bus, write-only.
- Runs the power-up and init sequence, then streams a ROWS x COLS frame from an external character source addressed by char_index.
- Adds over the previous generation:
  - configurable geometry;
  - power-on and post-clear wait states;
  - per-row DDRAM addressing;
  - one-shot or continuous refresh;
  - busy and frame_done status.
- Sits between the text/phrase ROM logic and the LCD pins.

Parameters:
- COLS, 16, characters per row (8..40).
- ROWS, 2, rows (1, 2 or 4).
- POWERUP_CYCLES, 20, clock cycles idle after reset before the first function set (20 x 2 ms = 40 ms).
- CLEAR_WAIT, 1, extra idle cycles after Clear Display (at least 1.52 ms).
- CONTINUOUS, 1, 1 = rewrite frame forever; 0 = write one frame per start pulse.

Ports:
- clock500Hz  in  1  system/LCD clock, 2 ms period
- reset  in  1  asynchronous, active-high
- start  in  1  frame request, sampled only in IDLE (CONTINUOUS=0)
- char_data  in  8  ASCII code for char_index, combinational from source
- char_index  out  IW=$clog2(ROWS*COLS)  linear index, row*COLS+col
- busy  out  1  high except in IDLE
- frame_done  out  1  one-cycle pulse after the last character of a frame
- RS  out  1  register select
- RW  out  1  read/write, tied 0
- E  out  1  enable strobe
- DB  out  8  data bus

Behaviour:
- Reset is asynchronous, active-high; clock is clock500Hz.
- Reset values:
  - state = POWER_WAIT, wait counter 0, row = col = 0, char_index = 0;
  - RS = 0, RW = 0, DB = 0x00, E = 0;
  - busy = 1, frame_done = 0.
- Moore FSM. RS and DB decode from the state register; in WRITE_CHAR, DB = char_data.
- E gating:
  - E = clock500Hz AND e_en.
  - e_en is registered on the negedge of clock500Hz, so E is glitch-free.
  - e_en = 1 in command and write states; 0 in POWER_WAIT, CLEAR_WAIT and IDLE.
- State sequence, one cycle each unless stated:
  - POWER_WAIT: POWERUP_CYCLES cycles.
  - FS1, FS2, FS3, FS4: DB = 0x38 when ROWS >= 2, 0x30 when ROWS = 1.
  - CLEAR: DB = 0x01.
  - CLEAR_WAIT: CLEAR_WAIT cycles, DB = 0x00.
  - DISP_CTRL: DB = 0x0C.
  - ENTRY: DB = 0x06.
  - Then SET_ADDR if CONTINUOUS = 1, otherwise IDLE.
- IDLE:
  - busy = 0.
  - start = 1 -> SET_ADDR on the next edge.
  - start is ignored in every other state, and in all states when CONTINUOUS = 1.
- SET_ADDR:
  - RS = 0, DB = 0x80 | base(row), next state WRITE_CHAR.
  - base: row 0 = 0x00, row 1 = 0x40, row 2 = COLS, row 3 = 0x40 + COLS.
- WRITE_CHAR:
  - RS = 1, DB = char_data.
  - On leaving: char_index increments, col increments.
  - col = COLS-1 -> col = 0, row increments, next SET_ADDR.
  - Last row and last column -> row = 0, char_index = 0, frame_done = 1 for one cycle.
  - Next state after the last character: SET_ADDR (continuous) or IDLE (one-shot).
- Frame latency: ROWS x (COLS + 1) cycles from the first SET_ADDR to frame_done.
- Init latency: POWERUP_CYCLES + 7 + CLEAR_WAIT cycles.
- char_index is stable for the whole WRITE_CHAR cycle; the source has one full cycle to respond.
- Index wrap: char_index never exceeds ROWS*COLS-1 and wraps to 0 at frame end only.
- Reset asserted mid-frame: immediate return to POWER_WAIT, E forced 0, full init re-run. The display is cleared, so no partial frame survives.
- Default state encoding (unused codes) -> POWER_WAIT.

Decomposition:
- Package lcd_pkg holds:
  - command constants: FUNC_SET_2L = 0x38, FUNC_SET_1L = 0x30, CLEAR = 0x01, DISP_ON = 0x0C, ENTRY_INC = 0x06, SET_DDRAM = 0x80, ROW1_BASE = 0x40;
  - the state enum.
- Sub-module lcd_cursor_counter holds:
  - row/col/char_index counters with advance and clear inputs;
  - last_col and last_char flags;
  - the row base-address output.
- The FSM module owns the wait counter, e_en and outputs.

Test Plan:
- Defaults, reset release -> 20 cycles with E = 0, then DB 0x38 x4, 0x01, one E = 0 cycle, 0x0C, 0x06, then SET_ADDR 0x80.
- 16x2 continuous, char_data = 0x41 + char_index -> DB 0x80, 'A'..'P', 0xC0, 'Q'..'`'; frame_done pulses after index 31, then 0x80 again.
- ROWS = 4, COLS = 20 -> addresses 0x80, 0xC0, 0x94, 0xD4; char_index 0..79 with no skip or overflow.
- CONTINUOUS = 0:
  - busy = 0 in IDLE; start pulse -> one frame, then IDLE.
  - start held during the frame -> no effect until IDLE.
- ROWS = 1 -> function set 0x30; frame is SET_ADDR 0x80 plus COLS writes.
- Reset pulse at char_index = 9 -> E low immediately; char_index = 0, busy = 1; full init repeated.
